// File: rtl/beep_timer_sched.sv
// Round-robin arbiter that lends one shared loop-mode timer to NREQ beep requesters,
// counts the timer's terminal-count pulses and gates the buzzer during ON phases.
module beep_timer_sched #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_period,
    input  logic [NREQ*8-1:0]    req_reps,
    input  logic                 timer_flag,
    output logic [31:0]          cnt_default,
    output logic                 mode,
    output logic                 ena,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 beep_en
);

    localparam int IDXW = $clog2(NREQ);
    localparam int GAPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] ptr);
        logic [IDXW:0]   res;
        logic [IDXW-1:0] cand_idx;
        int              cand;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand     = int'(ptr) + k;
            cand     = (cand >= NREQ) ? (cand - NREQ) : cand;
            cand_idx = IDXW'(cand);
            if (!res[IDXW] && r[cand_idx]) begin
                res = {1'b1, cand_idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t          state_r, state_nx;
    logic [NREQ-1:0] grant_r, grant_nx;
    logic [NREQ-1:0] done_r, done_nx;
    logic [IDXW-1:0] owner_r, owner_nx;
    logic [IDXW-1:0] rr_ptr_r, rr_ptr_nx;
    logic [7:0]      reps_r, reps_nx;
    logic [31:0]     cnt_default_r, cnt_nx;
    logic [8:0]      flag_cnt_r, flag_cnt_nx;
    logic [GAPW-1:0] gap_cnt_r, gap_cnt_nx;
    logic            ena_r, ena_nx;
    logic            beep_en_r, beep_nx;
    logic            busy_r, busy_nx;
    logic            mode_r;

    logic [IDXW:0]   pick_s;
    logic [IDXW-1:0] pick_idx_s;
    logic [31:0]     sel_period_s;
    logic [31:0]     eff_period_s;
    logic [7:0]      sel_reps_s;
    logic            owner_req_s;
    logic            enter_gap_s;
    logic [IDXW-1:0] owner_next_s;

    assign pick_s       = rr_pick(req, rr_ptr_r);
    assign pick_idx_s   = pick_s[IDXW-1:0];
    assign sel_period_s = req_period[32*pick_idx_s +: 32];
    assign eff_period_s = (sel_period_s == 32'd0) ? 32'd1 : sel_period_s;
    assign sel_reps_s   = req_reps[8*pick_idx_s +: 8];
    assign owner_req_s  = req[owner_r];
    assign owner_next_s = (owner_r == IDXW'(NREQ - 1)) ? '0 : (owner_r + IDXW'(1'b1));

    // Next-state and next-output logic; beep_en_r doubles as the ON/OFF phase bit.
    always_comb begin
        state_nx    = state_r;
        grant_nx    = grant_r;
        owner_nx    = owner_r;
        reps_nx     = reps_r;
        cnt_nx      = cnt_default_r;
        flag_cnt_nx = flag_cnt_r;
        gap_cnt_nx  = gap_cnt_r;
        rr_ptr_nx   = rr_ptr_r;
        ena_nx      = 1'b0;
        beep_nx     = 1'b0;
        busy_nx     = 1'b0;
        done_nx     = '0;
        enter_gap_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDXW]) begin
                    state_nx    = ST_LOAD;
                    owner_nx    = pick_idx_s;
                    grant_nx    = onehot(pick_idx_s);
                    cnt_nx      = eff_period_s;
                    reps_nx     = sel_reps_s;
                    flag_cnt_nx = 9'd0;
                    busy_nx     = 1'b1;
                end else begin
                    grant_nx = '0;
                end
            end
            ST_LOAD: begin
                if (!owner_req_s) begin
                    enter_gap_s = 1'b1;
                end else if (reps_r == 8'd0) begin
                    done_nx     = onehot(owner_r);
                    enter_gap_s = 1'b1;
                end else begin
                    state_nx = ST_RUN;
                    ena_nx   = 1'b1;
                    beep_nx  = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!owner_req_s) begin
                    enter_gap_s = 1'b1;
                end else if (timer_flag && ((flag_cnt_r + 9'd1) == {reps_r, 1'b0})) begin
                    done_nx     = onehot(owner_r);
                    enter_gap_s = 1'b1;
                end else if (timer_flag) begin
                    flag_cnt_nx = flag_cnt_r + 9'd1;
                    ena_nx      = 1'b1;
                    beep_nx     = ~beep_en_r;
                    busy_nx     = 1'b1;
                end else begin
                    ena_nx  = 1'b1;
                    beep_nx = beep_en_r;
                    busy_nx = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt_r - GAPW'(1'b1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase

        if (enter_gap_s) begin
            state_nx   = ST_GAP;
            grant_nx   = '0;
            gap_cnt_nx = GAPW'(GAP_CYCLES - 1);
            rr_ptr_nx  = owner_next_s;
        end else begin
            rr_ptr_nx = rr_ptr_r;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            done_r        <= '0;
            owner_r       <= '0;
            rr_ptr_r      <= '0;
            reps_r        <= 8'd0;
            cnt_default_r <= 32'd0;
            flag_cnt_r    <= 9'd0;
            gap_cnt_r     <= '0;
            ena_r         <= 1'b0;
            beep_en_r     <= 1'b0;
            busy_r        <= 1'b0;
            mode_r        <= 1'b0;
        end else begin
            state_r       <= state_nx;
            grant_r       <= grant_nx;
            done_r        <= done_nx;
            owner_r       <= owner_nx;
            rr_ptr_r      <= rr_ptr_nx;
            reps_r        <= reps_nx;
            cnt_default_r <= cnt_nx;
            flag_cnt_r    <= flag_cnt_nx;
            gap_cnt_r     <= gap_cnt_nx;
            ena_r         <= ena_nx;
            beep_en_r     <= beep_nx;
            busy_r        <= busy_nx;
            mode_r        <= 1'b0;
        end
    end

    assign cnt_default = cnt_default_r;
    assign mode        = mode_r;
    assign ena         = ena_r;
    assign grant       = grant_r;
    assign done        = done_r;
    assign busy        = busy_r;
    assign beep_en     = beep_en_r;

endmodule

// File: tb/tb_beep_timer_sched.sv
// Directed bench for beep_timer_sched with a loop-mode timer model driving timer_flag.
module tb_beep_timer_sched;

    localparam int NREQ = 4;
    localparam int GAP  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_period;
    logic [31:0]  req_reps;
    logic         timer_flag;
    logic [31:0]  cnt_default;
    logic         mode;
    logic         ena;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic         beep_en;
    logic [31:0]  tcnt = 32'd0;

    int checks = 0;
    int errors = 0;

    beep_timer_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_period(req_period), .req_reps(req_reps),
        .timer_flag(timer_flag), .cnt_default(cnt_default), .mode(mode), .ena(ena),
        .grant(grant), .done(done), .busy(busy), .beep_en(beep_en)
    );

    always #5 clk = ~clk;

    // Timer: pulses at every cnt_default-th enabled clock, reloads while disabled.
    assign timer_flag = ena && (tcnt == cnt_default - 32'd1);
    always @(posedge clk) begin
        if (!ena) tcnt <= 32'd0;
        else if (timer_flag) tcnt <= 32'd0;
        else tcnt <= tcnt + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] period;
        logic [7:0]  reps;
        logic [3:0]  exp_grant;
        int          exp_on;
        int          exp_ena;
        int          exp_run;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int          on_c = 0, ena_c = 0, run = 0, maxrun = 0, bad = 0;
        logic        got = 1'b0, seen_ena = 1'b0, first_beep = 1'b0;
        logic [3:0]  done_v = 4'd0, grant_at_done = 4'hf;
        logic [31:0] eff;
        eff = (v.period == 32'd0) ? 32'd1 : v.period;
        @(negedge clk);
        req_period = {4{v.period}};
        req_reps   = {4{v.reps}};
        req        = v.req;
        @(negedge clk);
        check("grant_next_clk", 32'(grant), 32'(v.exp_grant));
        check("busy_load", 32'(busy), 32'd1);
        check("ena_load", 32'(ena), 32'd0);
        check("cnt_default", cnt_default, eff);
        req_period = {4{32'd50}};
        req_reps   = {4{8'd9}};
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (ena && !seen_ena) begin
                seen_ena   = 1'b1;
                first_beep = beep_en;
            end
            if (ena) ena_c++;
            if (beep_en) begin
                on_c++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (done != 4'd0) begin
                got           = 1'b1;
                done_v        = done;
                grant_at_done = grant;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_index", 32'(done_v), 32'(v.exp_grant));
        check("grant_clear_at_done", 32'(grant_at_done), 32'd0);
        check("first_phase_on", 32'(first_beep), 32'(v.reps != 8'd0));
        check("beep_on_clks", on_c, v.exp_on);
        check("ena_clks", ena_c, v.exp_ena);
        check("on_phase_len", maxrun, v.exp_run);
        check("mode_zero", 32'(mode), 32'd0);
        req = 4'd0;
        for (int g = 0; g < GAP; g++) begin
            @(negedge clk);
            if (ena || beep_en || grant != 4'd0 || done != 4'd0) bad++;
        end
        check("gap_quiet", bad, 0);
        check("cnt_default_hold", cnt_default, eff);
    endtask

    // Directed sequence: table bursts, then round-robin, abort and async reset cases.
    initial begin
        logic [3:0] d_val [4];
        int         d_cyc [4];
        int         nd;
        int         bad;
        logic [3:0] e;

        vecs[0] = '{4'b0001, 32'd10, 8'd3, 4'b0001, 30, 60, 10};
        vecs[1] = '{4'b0010, 32'd0,  8'd1, 4'b0010, 1,  2,  1};
        vecs[2] = '{4'b0010, 32'd4,  8'd0, 4'b0010, 0,  0,  0};
        vecs[3] = '{4'b1001, 32'd3,  8'd2, 4'b1000, 6,  12, 3};
        vecs[4] = '{4'b1001, 32'd2,  8'd1, 4'b0001, 2,  4,  2};
        vecs[5] = '{4'b0101, 32'd7,  8'd2, 4'b0100, 14, 28, 7};

        rst        = 1'b1;
        req        = 4'd0;
        req_period = '0;
        req_reps   = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {cnt_default[27:0], mode, ena, busy, beep_en}, 32'd0);
        check("rst_grant_done", {24'd0, grant, done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Simultaneous requests from pointer 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req_period = {4{32'd5}};
        req_reps   = {4{8'd1}};
        req        = 4'b1111;
        nd         = 0;
        for (int k = 0; k < 4; k++) begin
            d_val[k] = 4'd0;
            d_cyc[k] = 0;
        end
        for (int cyc = 1; cyc <= 400 && nd < 4; cyc++) begin
            @(negedge clk);
            if (done != 4'd0) begin
                d_val[nd] = done;
                d_cyc[nd] = cyc;
                req       = req & ~done;
                nd++;
            end
        end
        check("rr_done_count", nd, 4);
        for (int k = 0; k < 4; k++) begin
            e = 4'b0001 << k;
            check("rr_order", 32'(d_val[k]), 32'(e));
        end
        for (int k = 1; k < 4; k++) check("rr_spacing", d_cyc[k] - d_cyc[k-1], 28);
        req = 4'd0;

        // Abort owner 2 during its first ON phase.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req_period = {4{32'd8}};
        req_reps   = {4{8'd2}};
        req        = 4'b0100;
        repeat (3) @(negedge clk);
        check("abort_pre_grant", 32'(grant), 32'b0100);
        check("abort_pre_beep", 32'(beep_en), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        check("abort_outputs", {29'd0, ena, beep_en, busy}, 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done != 4'd0) bad++;
        end
        check("abort_no_done", bad, 0);
        req = 4'b1001;
        @(negedge clk);
        check("abort_ptr_moves", 32'(grant), 32'b1000);

        // Asynchronous reset while owner 3 is running.
        repeat (4) @(negedge clk);
        check("pre_rst_ena", 32'(ena), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt", cnt_default, 32'd0);
        check("async_rst_ctl", {27'd0, mode, ena, busy, beep_en, 1'b0}, 32'd0);
        check("async_rst_grant_done", {24'd0, grant, done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_rst_ptr0", 32'(grant), 32'b0001);
        req = 4'd0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
